// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU and loader request ports plus shared read data.
// Requesters drive through the master modport, the arbiter uses the slave modport.
interface mem_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_lock;
  logic          c_gnt;
  logic          c_ack;
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_lock;
  logic          l_gnt;
  logic          l_ack;
  logic [DW-1:0] rdata;

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_lock,
    output l_req, l_we, l_addr, l_wdata, l_lock,
    input  c_gnt, c_ack, l_gnt, l_ack, rdata
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_lock,
    input  l_req, l_we, l_addr, l_wdata, l_lock,
    output c_gnt, c_ack, l_gnt, l_ack, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/loader arbiter owning the 16x8 unified memory.
// Optional owner lock for atomic RMW: define MEM_ARB_LOCK_EN.
module mem_arbiter #(
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 1 << AW
) (
  input  logic clk,
  input  logic rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ACK
  } state_e;

  state_e        state_q;
  logic          own_q;
  logic          last_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          c_gnt_q;
  logic          l_gnt_q;
  logic          c_ack_q;
  logic          l_ack_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic c_cand;
  logic l_cand;
  logic pick_l;

`ifdef MEM_ARB_LOCK_EN
  logic lock_q;
  logic lreq_q;
`else
  logic unused_lock;
  assign unused_lock = bus.c_lock ^ bus.l_lock;
`endif

  // own_q/last_q/pick_l: 1 = loader, 0 = CPU
  always_comb begin
    c_cand = bus.c_req;
    l_cand = bus.l_req;
`ifdef MEM_ARB_LOCK_EN
    if (lock_q) begin
      c_cand = bus.c_req & ~own_q;
      l_cand = bus.l_req & own_q;
    end
`endif
    pick_l = l_cand & (~c_cand | ~last_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      c_gnt_q <= 1'b0;
      l_gnt_q <= 1'b0;
      c_ack_q <= 1'b0;
      l_ack_q <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
      lock_q  <= 1'b0;
      lreq_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (c_cand | l_cand) begin
            state_q <= S_GRANT;
            own_q   <= pick_l;
            c_gnt_q <= ~pick_l;
            l_gnt_q <= pick_l;
            we_q    <= pick_l ? bus.l_we    : bus.c_we;
            addr_q  <= pick_l ? bus.l_addr  : bus.c_addr;
            wdata_q <= pick_l ? bus.l_wdata : bus.c_wdata;
`ifdef MEM_ARB_LOCK_EN
            lreq_q  <= pick_l ? bus.l_lock  : bus.c_lock;
            if (!lock_q) last_q <= pick_l;
`else
            last_q  <= pick_l;
`endif
          end
        end
        S_GRANT: begin
          if (we_q) begin
            mem_q[addr_q] <= wdata_q;
            rdata_q       <= wdata_q;
          end else begin
            rdata_q       <= mem_q[addr_q];
          end
          c_ack_q <= ~own_q;
          l_ack_q <= own_q;
          state_q <= S_ACK;
`ifdef MEM_ARB_LOCK_EN
          lock_q  <= lreq_q;
`endif
        end
        S_ACK: begin
          c_gnt_q <= 1'b0;
          l_gnt_q <= 1'b0;
          c_ack_q <= 1'b0;
          l_ack_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.c_gnt = c_gnt_q;
  assign bus.l_gnt = l_gnt_q;
  assign bus.c_ack = c_ack_q;
  assign bus.l_ack = l_ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: queued requests per port checked against
// a transaction-level arbitration and memory model.
module tb_mem_arbiter;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       lock;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(4), .DW(8)) bus ();

  mem_arbiter #(.AW(4), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  txn_t cq[$];
  txn_t lq[$];
  logic [7:0] ref_mem [16];
  logic [7:0] ref_rdata;
  bit ref_last;
  bit ref_locked;
  bit ref_lock_own;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.c_gnt, bus.l_gnt, bus.c_ack, bus.l_ack};
  endfunction

  function automatic txn_t mk(bit we, int addr, int wd, bit lk);
    txn_t t;
    t.we = we;
    t.addr = addr[3:0];
    t.wdata = wd[7:0];
    t.lock = lk;
    return t;
  endfunction

  task automatic present();
    txn_t z;
    z = '0;
    bus.c_req = (cq.size() != 0);
    bus.l_req = (lq.size() != 0);
    if (cq.size() != 0) z = cq[0];
    {bus.c_we, bus.c_addr, bus.c_wdata, bus.c_lock} = z;
    z = '0;
    if (lq.size() != 0) z = lq[0];
    {bus.l_we, bus.l_addr, bus.l_wdata, bus.l_lock} = z;
  endtask

  function automatic bit pick();
    bit c, l;
    c = (cq.size() != 0);
    l = (lq.size() != 0);
`ifdef MEM_ARB_LOCK_EN
    if (ref_locked) return ref_lock_own;
`endif
    if (c && !l) return 1'b0;
    if (l && !c) return 1'b1;
    return !ref_last;
  endfunction

  task automatic model_reset();
    ref_last = 1'b1;
    ref_locked = 1'b0;
    ref_lock_own = 1'b0;
    ref_rdata = 8'h00;
  endtask

  task automatic do_reset();
    cq.delete();
    lq.delete();
    present();
    rst_n = 1'b0;
    tick();
    tick();
    model_reset();
    chk("rst_outs", outs(), 4'b0000);
    chk("rst_rdata", bus.rdata, 8'h00);
    rst_n = 1'b1;
  endtask

  // Drains both queues; each transaction must grant, ack, and idle on
  // consecutive cycles with the winner chosen by the round-robin rules.
  task automatic run_seq();
    txn_t cur;
    bit own;
    int guard;
    guard = 0;
    present();
    while ((cq.size() + lq.size()) > 0 && guard < 64) begin
      guard++;
      own = pick();
      tick();
      chk(own ? "l_grant" : "c_grant", outs(), own ? 4'b0100 : 4'b1000);
      if (own) cur = lq.pop_front();
      else cur = cq.pop_front();
      present();
      if (cur.we) begin
        ref_mem[cur.addr] = cur.wdata;
        ref_rdata = cur.wdata;
      end else begin
        ref_rdata = ref_mem[cur.addr];
      end
`ifdef MEM_ARB_LOCK_EN
      if (!ref_locked) ref_last = own;
      ref_locked = cur.lock;
      ref_lock_own = own;
`else
      ref_last = own;
`endif
      tick();
      chk(own ? "l_ack" : "c_ack", outs(), own ? 4'b0101 : 4'b1010);
      chk("ack_rdata", bus.rdata, ref_rdata);
      tick();
      chk("idle_outs", outs(), 4'b0000);
      chk("rdata_hold", bus.rdata, ref_rdata);
    end
    chk("seq_budget", (guard < 64), 1'b1);
  endtask

  initial begin
    int nc, nl;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_lock = 0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0; bus.l_lock = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    model_reset();
    do_reset();

    // loader write then read of addr 0, CPU never granted
    lq.push_back(mk(1, 0, 8'h08, 0));
    lq.push_back(mk(0, 0, 0, 0));
    run_seq();

    // fill memory back-to-back from the loader
    for (int a = 0; a < 16; a++) lq.push_back(mk(1, a, $urandom_range(0, 255), 0));
    run_seq();

    lq.push_back(mk(1, 7, 8'h89, 0));
    run_seq();
    cq.push_back(mk(0, 7, 0, 0));
    run_seq();

    for (int i = 0; i < 20; i++) begin
      nc = $urandom_range(0, 2);
      nl = $urandom_range(0, 2);
      if (nc + nl == 0) nc = 1;
      for (int k = 0; k < nc; k++)
        cq.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255), 0));
      for (int k = 0; k < nl; k++)
        lq.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255), 0));
      run_seq();
    end

    // contention from reset: C,L,C,L
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cq.push_back(mk(1, $urandom_range(0, 15), $urandom_range(0, 255), 0));
      lq.push_back(mk(0, $urandom_range(0, 15), 0, 0));
    end
    run_seq();

    // reset during GRANT cancels the CPU write
    lq.push_back(mk(1, 5, 8'h55, 0));
    run_seq();
    cq.push_back(mk(1, 5, 8'hAA, 0));
    present();
    tick();
    chk("rstg_grant", outs(), 4'b1000);
    cq.delete();
    present();
    rst_n = 1'b0;
    tick();
    model_reset();
    chk("rstg_outs", outs(), 4'b0000);
    chk("rstg_rdata", bus.rdata, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("rstg_noack", outs(), 4'b0000);
    cq.push_back(mk(0, 5, 0, 0));
    run_seq();

    // CPU locked read-modify-write of addr 9 against a waiting loader
    cq.push_back(mk(0, 9, 0, 1));
    run_seq();
    cq.push_back(mk(0, 9, 0, 1));
    cq.push_back(mk(1, 9, $urandom_range(0, 255), 0));
    lq.push_back(mk(0, 3, 0, 0));
    present();
    bus.l_req = 1'b0;
    tick();
    chk("lock_c1_grant", outs(), 4'b1000);
    ref_rdata = ref_mem[9];
`ifdef MEM_ARB_LOCK_EN
    ref_locked = 1'b1;
    ref_lock_own = 1'b0;
`endif
    ref_last = 1'b0;
    void'(cq.pop_front());
    present();
    tick();
    chk("lock_c1_ack", outs(), 4'b1010);
    chk("lock_c1_rdata", bus.rdata, ref_rdata);
    tick();
    chk("lock_c1_idle", outs(), 4'b0000);
    run_seq();

    // loader request rising while c_ack is high
    cq.push_back(mk(0, 2, 0, 0));
    present();
    tick();
    chk("ovl_c_grant", outs(), 4'b1000);
    void'(cq.pop_front());
    present();
    ref_rdata = ref_mem[2];
    tick();
    chk("ovl_c_ack", outs(), 4'b1010);
    chk("ovl_c_rdata", bus.rdata, ref_rdata);
    lq.push_back(mk(0, 4, 0, 0));
    present();
    tick();
    chk("ovl_idle", outs(), 4'b0000);
    ref_last = 1'b0;
    run_seq();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
